mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 139 +++++++++++++
 tb/tb_mem_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: handshaked data-memory access with a timeout abort, a misalignment trap and the MEM/WB register.
// Optional stall-cycle counter output is enabled by defining MEM_STALL_COUNT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Branch_In,
  input  logic        MemRead_In,
  input  logic        MemtoReg_In,
  input  logic        MemWrite_In,
  input  logic        RegWrite_In,
  input  logic [31:0] Add_In,
  input  logic [31:0] ALUResult_In,
  input  logic [31:0] ReadData2_In,
  input  logic        Zero_In,
  input  logic [4:0]  Mux_In,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        mem_err,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
`ifdef MEM_STALL_COUNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        RegWrite_Out,
  output logic        MemtoReg_Out,
  output logic [31:0] ReadData_Out,
  output logic [31:0] ALUResult_Out,
  output logic [4:0]  WriteReg_Out
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state, next_state;
  logic [7:0] wait_cnt;
  logic       access, aligned, timeout_hit;
  logic       req_c, stall_c, complete, abort, misalign;

  assign access      = MemRead_In | MemWrite_In;
  assign aligned     = (ALUResult_In[1:0] == 2'b00);
  assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  assign PCSrc        = Branch_In & Zero_In;
  assign BranchTarget = Add_In;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // An ack arriving in the timeout cycle takes priority over the abort.
  always_comb begin
    next_state = state;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    misalign   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            req_c      = 1'b1;
            stall_c    = 1'b1;
            next_state = WAIT;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (mem_ack) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Gate with reset so an access in flight is dropped the moment reset asserts.
  assign mem_req   = req_c & reset;
  assign stall     = stall_c & reset;
  assign mem_we    = mem_req & MemWrite_In;
  assign mem_addr  = mem_req ? ALUResult_In : 32'h0;
  assign mem_wdata = mem_req ? ReadData2_In : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 wait_cnt <= 8'h0;
    else if (state == IDLE && next_state == WAIT) wait_cnt <= 8'h0;
    else if (state == WAIT && !mem_ack)         wait_cnt <= wait_cnt + 8'h1;
  end

  // MEM/WB register: stalled edges insert a bubble, faulted accesses suppress the write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite_Out  <= 1'b0;
      MemtoReg_Out  <= 1'b0;
      ReadData_Out  <= 32'h0;
      ALUResult_Out <= 32'h0;
      WriteReg_Out  <= 5'h0;
      mem_err       <= 1'b0;
    end else begin
      mem_err <= misalign | abort;
      if (stall) begin
        RegWrite_Out <= 1'b0;
        MemtoReg_Out <= 1'b0;
      end else begin
        RegWrite_Out  <= RegWrite_In & ~(misalign | abort);
        MemtoReg_Out  <= MemtoReg_In;
        ReadData_Out  <= complete ? mem_rdata : 32'h0;
        ALUResult_Out <= ALUResult_In;
        WriteReg_Out  <= Mux_In;
      end
    end
  end

`ifdef MEM_STALL_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          stall_cnt <= 32'h0;
    else if (stall && stall_cnt != '1)   stall_cnt <= stall_cnt + 32'h1;
  end
`else
  // Stall-cycle counter is not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage, built with TIMEOUT_CYCLES=4.
// Covers ALU pass-through, load/store handshakes, misalignment, timeout, branch and reset-in-flight.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        Branch_In, MemRead_In, MemtoReg_In, MemWrite_In, RegWrite_In;
  logic [31:0] Add_In, ALUResult_In, ReadData2_In;
  logic        Zero_In;
  logic [4:0]  Mux_In;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, mem_err, PCSrc;
  logic [31:0] BranchTarget;
`ifdef MEM_STALL_COUNT_EN
  logic [31:0] stall_cnt;
`endif
  logic        RegWrite_Out, MemtoReg_Out;
  logic [31:0] ReadData_Out, ALUResult_Out;
  logic [4:0]  WriteReg_Out;

  int assertCount = 0;
  int failCount   = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .Branch_In(Branch_In), .MemRead_In(MemRead_In), .MemtoReg_In(MemtoReg_In),
    .MemWrite_In(MemWrite_In), .RegWrite_In(RegWrite_In),
    .Add_In(Add_In), .ALUResult_In(ALUResult_In), .ReadData2_In(ReadData2_In),
    .Zero_In(Zero_In), .Mux_In(Mux_In),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .mem_err(mem_err), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
`ifdef MEM_STALL_COUNT_EN
    .stall_cnt(stall_cnt),
`endif
    .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
    .ReadData_Out(ReadData_Out), .ALUResult_Out(ALUResult_Out), .WriteReg_Out(WriteReg_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic rw, input logic m2r,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dst);
    MemRead_In   = rd;
    MemWrite_In  = wr;
    RegWrite_In  = rw;
    MemtoReg_In  = m2r;
    ALUResult_In = addr;
    ReadData2_In = wdata;
    Mux_In       = dst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    Branch_In = 1'b0; Zero_In = 1'b0; Add_In = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #8;
    checkOutput("reset_regwrite", 32'(RegWrite_Out), 32'h0);
    checkOutput("reset_aluresult", ALUResult_Out, 32'h0);
    checkOutput("reset_writereg", 32'(WriteReg_Out), 32'h0);
    checkOutput("reset_err", 32'(mem_err), 32'h0);
    checkOutput("reset_req", 32'(mem_req), 32'h0);
    #4 reset = 1'b1;
    tick();

    $display("[TB] ALU pass-through and branch");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
    Branch_In = 1'b1; Zero_In = 1'b1; Add_In = 32'h200;
    #1;
    checkOutput("alu_stall", 32'(stall), 32'h0);
    checkOutput("alu_req", 32'(mem_req), 32'h0);
    checkOutput("idle_addr_zero", mem_addr, 32'h0);
    checkOutput("branch_pcsrc", 32'(PCSrc), 32'h1);
    checkOutput("branch_target", BranchTarget, 32'h200);
    tick();
    checkOutput("alu_regwrite", 32'(RegWrite_Out), 32'h1);
    checkOutput("alu_result", ALUResult_Out, 32'h10);
    checkOutput("alu_writereg", 32'(WriteReg_Out), 32'd5);
    Zero_In = 1'b0;
    #1;
    checkOutput("branch_not_taken", 32'(PCSrc), 32'h0);
    Branch_In = 1'b0;

    $display("[TB] Load with ack on third cycle after request");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd7);
    #1;
    checkOutput("load_req", 32'(mem_req), 32'h1);
    checkOutput("load_stall0", 32'(stall), 32'h1);
    checkOutput("load_addr", mem_addr, 32'h40);
    checkOutput("load_we", 32'(mem_we), 32'h0);
    tick();
    checkOutput("load_stall1", 32'(stall), 32'h1);
    checkOutput("load_bubble1", 32'(RegWrite_Out), 32'h0);
    tick();
    checkOutput("load_stall2", 32'(stall), 32'h1);
    checkOutput("load_bubble2", 32'(RegWrite_Out), 32'h0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("load_ack_stall", 32'(stall), 32'h0);
    checkOutput("load_bubble3", 32'(RegWrite_Out), 32'h0);
    tick();
    checkOutput("load_rdata", ReadData_Out, 32'hDEADBEEF);
    checkOutput("load_memtoreg", 32'(MemtoReg_Out), 32'h1);
    checkOutput("load_regwrite", 32'(RegWrite_Out), 32'h1);
    checkOutput("load_writereg", 32'(WriteReg_Out), 32'd7);
    checkOutput("load_err", 32'(mem_err), 32'h0);
`ifdef MEM_STALL_COUNT_EN
    checkOutput("stall_cnt", stall_cnt, 32'd3);
`endif
    mem_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    $display("[TB] Store, write wins over read");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h1234, 5'd3);
    #1;
    checkOutput("store_we", 32'(mem_we), 32'h1);
    checkOutput("store_addr", mem_addr, 32'h44);
    checkOutput("store_wdata", mem_wdata, 32'h1234);
    tick();
    checkOutput("store_we_wait", 32'(mem_we), 32'h1);
    checkOutput("store_wdata_wait", mem_wdata, 32'h1234);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
    tick();
    mem_ack = 1'b0;
    checkOutput("store_regwrite", 32'(RegWrite_Out), 32'h0);
    checkOutput("store_err", 32'(mem_err), 32'h0);
    MemRead_In = 1'b0; MemWrite_In = 1'b0;
    #1;
    checkOutput("idle_we_zero", 32'(mem_we), 32'h0);
    checkOutput("idle_wdata_zero", mem_wdata, 32'h0);

    $display("[TB] Timeout abort after four WAIT cycles");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 5'd4);
    tick();
    checkOutput("to_wait1_stall", 32'(stall), 32'h1);
    tick();
    tick();
    checkOutput("to_wait3_stall", 32'(stall), 32'h1);
    tick();
    checkOutput("to_wait4_stall", 32'(stall), 32'h0);
    checkOutput("to_wait4_req", 32'(mem_req), 32'h1);
    tick();
    checkOutput("to_err", 32'(mem_err), 32'h1);
    checkOutput("to_regwrite", 32'(RegWrite_Out), 32'h0);
    checkOutput("to_rdata", ReadData_Out, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    checkOutput("to_err_pulse", 32'(mem_err), 32'h0);

    $display("[TB] Ack in timeout cycle wins");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h84, 32'h0, 5'd6);
    tick();
    tick();
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_ack = 1'b0;
    checkOutput("race_err", 32'(mem_err), 32'h0);
    checkOutput("race_rdata", ReadData_Out, 32'h0BADF00D);
    checkOutput("race_regwrite", 32'(RegWrite_Out), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    $display("[TB] Misaligned load");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h42, 32'h0, 5'd9);
    #1;
    checkOutput("mis_req", 32'(mem_req), 32'h0);
    checkOutput("mis_stall", 32'(stall), 32'h0);
    tick();
    checkOutput("mis_err", 32'(mem_err), 32'h1);
    checkOutput("mis_regwrite", 32'(RegWrite_Out), 32'h0);
    checkOutput("mis_writereg", 32'(WriteReg_Out), 32'd9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    checkOutput("mis_err_pulse", 32'(mem_err), 32'h0);

    $display("[TB] Reset during WAIT");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h88, 32'h0, 5'd2);
    tick();
    checkOutput("rst_pre_req", 32'(mem_req), 32'h1);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_req", 32'(mem_req), 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'h0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_aluresult", ALUResult_Out, 32'h0);
    checkOutput("rst_writereg", 32'(WriteReg_Out), 32'h0);
    checkOutput("rst_memtoreg", 32'(MemtoReg_Out), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    #1 reset = 1'b1;
    tick();
    checkOutput("late_ack_rdata", ReadData_Out, 32'h0);
    checkOutput("late_ack_err", 32'(mem_err), 32'h0);
    checkOutput("late_ack_stall", 32'(stall), 32'h0);
    mem_ack = 1'b0;
    tick();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
